// File: rtl/spi_txn_sequencer_if.sv
// Bundle of every non-clock/reset signal of the SPI transaction sequencer.
// The sequencer takes the master modport (it drives the SPI master's start and
// tx_data); the environment around it takes the slave modport.
interface spi_txn_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Byte stream in / received bytes out
    logic [DATA_WIDTH-1:0] s_tx_data;
    logic                  s_tx_valid;
    logic                  s_tx_ready;
    logic [DATA_WIDTH-1:0] m_rx_data;
    logic                  m_rx_valid;
    logic                  m_rx_ready;

    // SPI master side
    logic                  spi_start;
    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic [DATA_WIDTH-1:0] spi_rx_data;
    logic                  spi_done;

    // Control and status
    logic                  clear_err;
    logic                  busy;
    logic                  timeout_err;
    logic [CW-1:0]         tx_count;
    logic [CW-1:0]         rx_count;

    modport master (
        input  s_tx_data, s_tx_valid, m_rx_ready, spi_rx_data, spi_done, clear_err,
        output s_tx_ready, m_rx_data, m_rx_valid, spi_start, spi_tx_data,
               busy, timeout_err, tx_count, rx_count
    );

    modport slave (
        output s_tx_data, s_tx_valid, m_rx_ready, spi_rx_data, spi_done, clear_err,
        input  s_tx_ready, m_rx_data, m_rx_valid, spi_start, spi_tx_data,
               busy, timeout_err, tx_count, rx_count
    );
endinterface

// File: rtl/spi_txn_sequencer.sv
// SPI transaction sequencer: TX FIFO -> one SPI master transaction per byte ->
// RX FIFO, with a programmable inter-byte gap and a watchdog on spi_done.

// Show-ahead FIFO with circular pointers; callers never push when full or pop
// when empty, so no overflow/underflow guarding is done here.
module spi_txn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

module spi_txn_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_txn_sequencer_if.master  bus
);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    // One counter serves both the watchdog and the gap timer
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
    // With no gap configured, a finished transaction returns straight to IDLE
    localparam state_t AFTER_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] spi_tx_data_reg, spi_tx_data_next;
    logic                  timeout_err_reg, timeout_err_next;

    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  tx_ready, rx_valid, start_pulse;
    logic [DATA_WIDTH-1:0] tx_head, rx_head;
    logic [CW-1:0]         tx_count, rx_count;

    assign tx_ready = (tx_count != CW'(FIFO_DEPTH));
    assign rx_valid = (rx_count != '0);
    assign tx_push  = bus.s_tx_valid && tx_ready;
    assign rx_pop   = rx_valid && bus.m_rx_ready;

    spi_txn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (bus.s_tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    spi_txn_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (bus.spi_rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count)
    );

    // State, counter, held tx byte and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            spi_tx_data_reg <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            spi_tx_data_reg <= spi_tx_data_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Next-state and transaction control. The byte is latched and popped when
    // leaving IDLE so spi_tx_data is already valid during the spi_start cycle.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        spi_tx_data_next = spi_tx_data_reg;
        timeout_err_next = timeout_err_reg;
        tx_pop           = 1'b0;
        rx_push          = 1'b0;
        start_pulse      = 1'b0;

        // Clear first so that a set later in this block takes priority
        if (bus.clear_err) timeout_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // Only start when there is room to land the reply
                if (tx_count != '0 && rx_count != CW'(FIFO_DEPTH)) begin
                    state_next       = START;
                    tx_pop           = 1'b1;
                    spi_tx_data_next = tx_head;
                end
            end
            START: begin
                start_pulse = 1'b1;
                cnt_next    = '0;
                state_next  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.spi_done) begin
                    rx_push    = 1'b1;
                    cnt_next   = '0;
                    state_next = AFTER_WAIT;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = AFTER_WAIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.s_tx_ready  = tx_ready;
    assign bus.m_rx_valid  = rx_valid;
    assign bus.m_rx_data   = rx_head;
    assign bus.spi_start   = start_pulse;
    assign bus.spi_tx_data = spi_tx_data_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.timeout_err = timeout_err_reg;
    assign bus.tx_count    = tx_count;
    assign bus.rx_count    = rx_count;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Testbench for spi_txn_sequencer: behavioural SPI master model plus
// arrays of pushed / transmitted / returned bytes as the reference.
module tb_spi_txn_sequencer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_txn_sequencer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    spi_txn_sequencer #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference bookkeeping written by the stimulus side
    logic [7:0] exp_tx_arr [0:255];
    int         exp_tx_n = 0;
    int         rx_rd    = 0;

    // Master model controls (written by stimulus only)
    int         resp_delay  = 3;
    bit         stall       = 1'b0;
    bit         fixed_en    = 1'b0;
    logic [7:0] fixed_val   = 8'h00;
    int         abandon_req = 0;
    int         inject_req  = 0;

    // Master model state (written by the model only)
    logic [7:0] sent_arr   [0:255];
    int         sent_n       = 0;
    logic [7:0] exp_rx_arr [0:255];
    int         exp_rx_n     = 0;
    int         abandon_seen = 0;
    int         inject_seen  = 0;
    bit         pending      = 1'b0;
    int         left         = 0;
    logic [7:0] cur_tx       = 8'h00;
    int         unstable_cnt = 0;
    int         spacing_viol = 0;
    int         last_start   = -100;

    // SPI master model: records each started byte, answers with spi_done
    // resp_delay cycles after spi_start, and tracks tx_data stability
    always @(negedge clk) begin
        logic [7:0] v;
        bus.spi_done = 1'b0;
        if (abandon_seen != abandon_req) begin
            pending      = 1'b0;
            abandon_seen = abandon_req;
        end
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (bus.spi_tx_data !== cur_tx) unstable_cnt++;
                if (!stall) begin
                    left--;
                    if (left <= 0) begin
                        v = fixed_en ? fixed_val : 8'($urandom);
                        bus.spi_rx_data = v;
                        bus.spi_done    = 1'b1;
                        exp_rx_arr[exp_rx_n] = v;
                        exp_rx_n++;
                        pending = 1'b0;
                        $display("[%0d] master done rx=%h", cyc, v);
                    end
                end
            end
            if (bus.spi_start === 1'b1) begin
                if (cyc - last_start < 3 + GAP) spacing_viol++;
                last_start       = cyc;
                sent_arr[sent_n] = bus.spi_tx_data;
                sent_n++;
                cur_tx  = bus.spi_tx_data;
                pending = 1'b1;
                left    = resp_delay;
                $display("[%0d] master start tx=%h", cyc, bus.spi_tx_data);
            end
        end
        if (inject_seen != inject_req) begin
            inject_seen     = inject_req;
            bus.spi_rx_data = 8'hEE;
            bus.spi_done    = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        int n = 0;
        while (bus.s_tx_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL push_wait: s_tx_ready stuck at %b, want 1", bus.s_tx_ready); end
        bus.s_tx_data  = v;
        bus.s_tx_valid = 1'b1;
        tick();
        bus.s_tx_valid = 1'b0;
        exp_tx_arr[exp_tx_n] = v;
        exp_tx_n++;
        $display("[%0d] push %h", cyc, v);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.s_tx_ready  !== 1'b1) begin errors++; $display("FAIL reset_s_tx_ready: got %b want 1", bus.s_tx_ready); end
        checks++; if (bus.m_rx_valid  !== 1'b0) begin errors++; $display("FAIL reset_m_rx_valid: got %b want 0", bus.m_rx_valid); end
        checks++; if (bus.spi_start   !== 1'b0) begin errors++; $display("FAIL reset_spi_start: got %b want 0", bus.spi_start); end
        checks++; if (bus.spi_tx_data !== 8'h00) begin errors++; $display("FAIL reset_spi_tx_data: got %h want 00", bus.spi_tx_data); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
        checks++; if (bus.busy        !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.tx_count    !== 3'd0) begin errors++; $display("FAIL reset_tx_count: got %0d want 0", bus.tx_count); end
        checks++; if (bus.rx_count    !== 3'd0) begin errors++; $display("FAIL reset_rx_count: got %0d want 0", bus.rx_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        int s0 = sent_n;
        int n  = 0;
        fixed_en = 1'b1; fixed_val = 8'h3C; resp_delay = 20; stall = 1'b0;
        bus.m_rx_ready = 1'b0;
        push_byte(8'hA5);
        checks++; if (bus.tx_count  !== 3'd1) begin errors++; $display("FAIL single_tx_count: got %0d want 1", bus.tx_count); end
        checks++; if (bus.spi_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", bus.spi_start); end
        tick();
        checks++; if (bus.spi_start   !== 1'b1)  begin errors++; $display("FAIL single_start: got %b want 1", bus.spi_start); end
        checks++; if (bus.spi_tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h want a5", bus.spi_tx_data); end
        checks++; if (bus.busy        !== 1'b1)  begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
        while (bus.m_rx_valid !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != 21) begin errors++; $display("FAIL single_latency: got %0d cycles want 21", n); end
        checks++; if (bus.m_rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h want 3c", bus.m_rx_data); end
        checks++; if (sent_n - s0 != 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", sent_n - s0); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL single_tx_stable: got %0d changes want 0", unstable_cnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_gap0_busy: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_gap1_busy: got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
        bus.m_rx_ready = 1'b1;
        $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
        rx_rd++;
        tick();
        bus.m_rx_ready = 1'b0;
        checks++; if (bus.rx_count !== 3'd0) begin errors++; $display("FAIL single_rx_count: got %0d want 0", bus.rx_count); end
        fixed_en = 1'b0;
    endtask

    task automatic test_tx_full_wrap();
        int s0 = sent_n;
        int e0 = exp_tx_n;
        int n  = 0;
        stall = 1'b1; resp_delay = 2; bus.m_rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        checks++; if (bus.s_tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.s_tx_ready); end
        checks++; if (bus.tx_count !== 3'd4) begin errors++; $display("FAIL full_tx_count: got %0d want 4", bus.tx_count); end
        repeat (5) tick();
        checks++; if (sent_n - s0 != 1) begin errors++; $display("FAIL full_outstanding: got %0d starts want 1", sent_n - s0); end
        stall = 1'b0;
        bus.m_rx_ready = 1'b1;
        while ((sent_n - s0 < 5 || bus.busy !== 1'b0 || bus.m_rx_valid === 1'b1) && n < 500) begin
            if (bus.m_rx_valid === 1'b1 && bus.m_rx_ready === 1'b1) begin
                checks++;
                if (rx_rd >= exp_rx_n) begin errors++; $display("FAIL full_rx_extra: got %h want no data", bus.m_rx_data); end
                else begin
                    if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL full_rx_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
                    $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
                    rx_rd++;
                end
            end
            tick(); n++;
        end
        bus.m_rx_ready = 1'b0;
        checks++; if (n >= 500) begin errors++; $display("FAIL full_drain_timeout: got %0d cycles want <500", n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sent_arr[s0+i] !== exp_tx_arr[e0+i] || sent_arr[s0+i] !== 8'(i+1))
                begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, sent_arr[s0+i], exp_tx_arr[e0+i]); end
        end
        checks++; if (rx_rd != exp_rx_n) begin errors++; $display("FAIL full_rx_all: got %0d pops want %0d", rx_rd, exp_rx_n); end
    endtask

    task automatic test_rx_backpressure();
        int s0 = sent_n;
        int e0 = exp_tx_n;
        int n  = 0;
        stall = 1'b0; resp_delay = 3; bus.m_rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        repeat (60) tick();
        checks++; if (sent_n - s0 != 4) begin errors++; $display("FAIL bp_starts: got %0d want 4", sent_n - s0); end
        checks++; if (bus.rx_count !== 3'd4) begin errors++; $display("FAIL bp_rx_count: got %0d want 4", bus.rx_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy %b want 0", bus.busy); end
        checks++; if (bus.tx_count !== 3'd2) begin errors++; $display("FAIL bp_tx_count: got %0d want 2", bus.tx_count); end
        checks++; if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL bp_pop_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
        bus.m_rx_ready = 1'b1;
        $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
        rx_rd++;
        tick();
        bus.m_rx_ready = 1'b0;
        while (sent_n - s0 < 5 && n < 20) begin tick(); n++; end
        checks++; if (sent_n - s0 != 5) begin errors++; $display("FAIL bp_fifth_start: got %0d starts want 5", sent_n - s0); end
        n = 0;
        bus.m_rx_ready = 1'b1;
        while ((sent_n - s0 < 6 || bus.busy !== 1'b0 || bus.m_rx_valid === 1'b1) && n < 500) begin
            if (bus.m_rx_valid === 1'b1 && bus.m_rx_ready === 1'b1) begin
                checks++;
                if (rx_rd >= exp_rx_n) begin errors++; $display("FAIL bp_rx_extra: got %h want no data", bus.m_rx_data); end
                else begin
                    if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL bp_rx_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
                    $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
                    rx_rd++;
                end
            end
            tick(); n++;
        end
        bus.m_rx_ready = 1'b0;
        checks++; if (n >= 500) begin errors++; $display("FAIL bp_drain_timeout: got %0d cycles want <500", n); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sent_arr[s0+i] !== exp_tx_arr[e0+i]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, sent_arr[s0+i], exp_tx_arr[e0+i]); end
        end
        checks++; if (rx_rd != exp_rx_n) begin errors++; $display("FAIL bp_rx_all: got %0d pops want %0d", rx_rd, exp_rx_n); end
    endtask

    task automatic test_timeout();
        int s0   = sent_n;
        int erx0 = exp_rx_n;
        int n    = 0;
        stall = 1'b1; bus.m_rx_ready = 1'b0;
        push_byte(8'($urandom));
        while (bus.spi_start !== 1'b1 && n < 10) begin tick(); n++; end
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n != 257) begin errors++; $display("FAIL tmo_latency: got %0d cycles want 257", n); end
        checks++; if (bus.rx_count !== 3'd0 || exp_rx_n != erx0) begin errors++; $display("FAIL tmo_no_push: got rx_count %0d want 0", bus.rx_count); end
        abandon_req++;
        stall = 1'b0; resp_delay = 4;
        push_byte(8'($urandom));
        n = 0;
        bus.m_rx_ready = 1'b1;
        while ((sent_n - s0 < 2 || bus.busy !== 1'b0 || bus.m_rx_valid === 1'b1) && n < 100) begin
            if (bus.m_rx_valid === 1'b1 && bus.m_rx_ready === 1'b1) begin
                checks++;
                if (rx_rd >= exp_rx_n) begin errors++; $display("FAIL tmo_rx_extra: got %h want no data", bus.m_rx_data); end
                else begin
                    if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL tmo_rx_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
                    $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
                    rx_rd++;
                end
            end
            tick(); n++;
        end
        bus.m_rx_ready = 1'b0;
        checks++; if (sent_n - s0 != 2 || rx_rd != exp_rx_n) begin errors++; $display("FAIL tmo_next_byte: got %0d starts %0d pops want 2 starts %0d pops", sent_n - s0, rx_rd, exp_rx_n); end
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", bus.timeout_err); end
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", bus.timeout_err); end
    endtask

    task automatic test_done_at_limit();
        int n = 0;
        stall = 1'b0; resp_delay = 256; bus.m_rx_ready = 1'b0;
        push_byte(8'($urandom));
        while (bus.spi_start !== 1'b1 && n < 10) begin tick(); n++; end
        n = 0;
        while (bus.m_rx_valid !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n != 257) begin errors++; $display("FAIL limit_latency: got %0d cycles want 257", n); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL limit_err: got %b want 0", bus.timeout_err); end
        checks++; if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL limit_rx_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
        bus.m_rx_ready = 1'b1;
        $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
        rx_rd++;
        tick();
        bus.m_rx_ready = 1'b0;
        repeat (4) tick();
        checks++; if (bus.rx_count !== 3'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL limit_after: got rx_count %0d err %b want 0 0", bus.rx_count, bus.timeout_err); end
    endtask

    task automatic test_back_to_back();
        int s0  = sent_n;
        int e0  = exp_tx_n;
        int idx = 0;
        int n   = 0;
        logic [7:0] v;
        stall = 1'b0;
        while ((idx < 12 || sent_n - s0 < 12 || bus.busy !== 1'b0 || bus.m_rx_valid === 1'b1) && n < 3000) begin
            bus.m_rx_ready = 1'($urandom_range(0, 1));
            resp_delay     = int'($urandom_range(1, 6));
            if (idx < 12 && bus.s_tx_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                bus.s_tx_data  = v;
                bus.s_tx_valid = 1'b1;
                exp_tx_arr[exp_tx_n] = v;
                exp_tx_n++;
                idx++;
                $display("[%0d] push %h", cyc, v);
            end else begin
                bus.s_tx_valid = 1'b0;
            end
            if (bus.m_rx_valid === 1'b1 && bus.m_rx_ready === 1'b1) begin
                checks++;
                if (rx_rd >= exp_rx_n) begin errors++; $display("FAIL b2b_rx_extra: got %h want no data", bus.m_rx_data); end
                else begin
                    if (bus.m_rx_data !== exp_rx_arr[rx_rd]) begin errors++; $display("FAIL b2b_rx_data: got %h want %h", bus.m_rx_data, exp_rx_arr[rx_rd]); end
                    $display("[%0d] rx pop %h", cyc, bus.m_rx_data);
                    rx_rd++;
                end
            end
            tick(); n++;
        end
        bus.s_tx_valid = 1'b0;
        bus.m_rx_ready = 1'b0;
        checks++; if (n >= 3000) begin errors++; $display("FAIL b2b_timeout: got %0d cycles want <3000", n); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (sent_arr[s0+i] !== exp_tx_arr[e0+i]) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, sent_arr[s0+i], exp_tx_arr[e0+i]); end
        end
        checks++; if (rx_rd != exp_rx_n) begin errors++; $display("FAIL b2b_rx_all: got %0d pops want %0d", rx_rd, exp_rx_n); end
        checks++; if (spacing_viol != 0) begin errors++; $display("FAIL b2b_spacing: got %0d violations want 0", spacing_viol); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL b2b_tx_stable: got %0d changes want 0", unstable_cnt); end
    endtask

    task automatic test_reset_mid();
        int s0 = sent_n;
        stall = 1'b1; bus.m_rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b1 || bus.tx_count !== 3'd3) begin errors++; $display("FAIL rmid_pre: got busy %b tx_count %0d want 1 3", bus.busy, bus.tx_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.s_tx_ready  !== 1'b1)  begin errors++; $display("FAIL rmid_s_tx_ready: got %b want 1", bus.s_tx_ready); end
        checks++; if (bus.m_rx_valid  !== 1'b0)  begin errors++; $display("FAIL rmid_m_rx_valid: got %b want 0", bus.m_rx_valid); end
        checks++; if (bus.spi_start   !== 1'b0)  begin errors++; $display("FAIL rmid_spi_start: got %b want 0", bus.spi_start); end
        checks++; if (bus.spi_tx_data !== 8'h00) begin errors++; $display("FAIL rmid_spi_tx_data: got %h want 00", bus.spi_tx_data); end
        checks++; if (bus.busy        !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.tx_count    !== 3'd0)  begin errors++; $display("FAIL rmid_tx_count: got %0d want 0", bus.tx_count); end
        checks++; if (bus.rx_count    !== 3'd0)  begin errors++; $display("FAIL rmid_rx_count: got %0d want 0", bus.rx_count); end
        abandon_req++;
        inject_req++;
        stall = 1'b0;
        repeat (5) tick();
        checks++; if (bus.rx_count !== 3'd0 || bus.m_rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_late_done: got rx_count %0d valid %b want 0 0", bus.rx_count, bus.m_rx_valid); end
        checks++; if (bus.busy !== 1'b0 || sent_n - s0 != 1) begin errors++; $display("FAIL rmid_quiet: got busy %b starts %0d want 0 1", bus.busy, sent_n - s0); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", bus.timeout_err); end
    endtask

    initial begin
        bus.s_tx_data  = '0;
        bus.s_tx_valid = 1'b0;
        bus.m_rx_ready = 1'b0;
        bus.clear_err  = 1'b0;
        test_reset();
        test_single_byte();
        test_tx_full_wrap();
        test_rx_backpressure();
        test_timeout();
        test_done_at_limit();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a bounded wait is itself broken
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "simulation time limit");
    end
endmodule
